// File: rtl/lane_sweep_ctrl.sv
// Sweep controller for the lane memoryfile: load, then read/process/write each lane, then save.
// Optional LANE_CHECKSUM_EN adds an XOR checksum of every lane written back during the sweep.
module lane_sweep_ctrl #(
  parameter int NUM_LANES = 25,
  parameter int LANE_W    = 64,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_load,
  output logic              mem_save,
  output logic              mem_read,
  output logic              mem_write,
  output logic [IDX_W-1:0]  mem_idx,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic [LANE_W-1:0] mem_wdata,
  output logic [LANE_W-1:0] lane_out,
  output logic [IDX_W-1:0]  lane_out_idx,
  output logic              lane_out_valid,
  input  logic              lane_out_ready,
  input  logic [LANE_W-1:0] lane_in,
  input  logic              lane_in_valid,
  output logic              lane_in_ready
`ifdef LANE_CHECKSUM_EN
  ,
  output logic [LANE_W-1:0] checksum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RD, S_CAP, S_SEND, S_RECV, S_WR, S_SAVE, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LANE_W-1:0]   lane_out_q, lane_out_d;
  logic [IDX_W-1:0]    lane_out_idx_q, lane_out_idx_d;
  logic [LANE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_load_q, mem_load_d;
  logic                mem_save_q, mem_save_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                lane_out_valid_q, lane_out_valid_d;
  logic                lane_in_ready_q, lane_in_ready_d;
`ifdef LANE_CHECKSUM_EN
  logic [LANE_W-1:0]   checksum_q, checksum_d;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    lane_out_d     = lane_out_q;
    lane_out_idx_d = lane_out_idx_q;
    mem_wdata_d    = mem_wdata_q;
`ifdef LANE_CHECKSUM_EN
    checksum_d     = checksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
`ifdef LANE_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      S_LOAD: state_d = S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        lane_out_d     = mem_rdata;
        lane_out_idx_d = idx_q;
        state_d        = S_SEND;
      end
      S_SEND: begin
        if (lane_out_ready) state_d = S_RECV;
      end
      S_RECV: begin
        if (lane_in_valid) begin
          mem_wdata_d = lane_in;
          state_d     = S_WR;
        end
      end
      S_WR: begin
`ifdef LANE_CHECKSUM_EN
        checksum_d = checksum_q ^ mem_wdata_q;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = S_SAVE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD;
        end
      end
      S_SAVE: state_d = S_DONE;
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered yet aligned with the state.
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
    mem_load_d       = (state_d == S_LOAD);
    mem_save_d       = (state_d == S_SAVE);
    mem_read_d       = (state_d == S_RD);
    mem_write_d      = (state_d == S_WR);
    lane_out_valid_d = (state_d == S_SEND);
    lane_in_ready_d  = (state_d == S_RECV);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      lane_out_q       <= '0;
      lane_out_idx_q   <= '0;
      mem_wdata_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mem_load_q       <= 1'b0;
      mem_save_q       <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      lane_out_valid_q <= 1'b0;
      lane_in_ready_q  <= 1'b0;
`ifdef LANE_CHECKSUM_EN
      checksum_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      lane_out_q       <= lane_out_d;
      lane_out_idx_q   <= lane_out_idx_d;
      mem_wdata_q      <= mem_wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mem_load_q       <= mem_load_d;
      mem_save_q       <= mem_save_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      lane_out_valid_q <= lane_out_valid_d;
      lane_in_ready_q  <= lane_in_ready_d;
`ifdef LANE_CHECKSUM_EN
      checksum_q       <= checksum_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_load       = mem_load_q;
  assign mem_save       = mem_save_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_idx        = idx_q;
  assign mem_wdata      = mem_wdata_q;
  assign lane_out       = lane_out_q;
  assign lane_out_idx   = lane_out_idx_q;
  assign lane_out_valid = lane_out_valid_q;
  assign lane_in_ready  = lane_in_ready_q;
`ifdef LANE_CHECKSUM_EN
  assign checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_lane_sweep_ctrl.sv
// Directed bench for lane_sweep_ctrl with a lane memory model and a downstream responder.
// Define LANE_CHECKSUM_EN to also exercise the checksum output.
module tb_lane_sweep_ctrl;
  localparam int NL = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_load, mem_save, mem_read, mem_write;
  logic [4:0]  mem_idx;
  logic [63:0] mem_rdata = '0;
  logic [63:0] mem_wdata, lane_out;
  logic [4:0]  lane_out_idx;
  logic        lane_out_valid;
  logic        lane_out_ready = 1'b0;
  logic [63:0] lane_in = '0;
  logic        lane_in_valid = 1'b0;
  logic        lane_in_ready;
`ifdef LANE_CHECKSUM_EN
  logic [63:0] checksum;
`endif

  lane_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_load(mem_load), .mem_save(mem_save), .mem_read(mem_read), .mem_write(mem_write),
    .mem_idx(mem_idx), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .lane_out(lane_out), .lane_out_idx(lane_out_idx), .lane_out_valid(lane_out_valid),
    .lane_out_ready(lane_out_ready), .lane_in(lane_in), .lane_in_valid(lane_in_valid),
    .lane_in_ready(lane_in_ready)
`ifdef LANE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Environment state: written only by the negedge model process below.
  logic [63:0] mem [NL];
  int          wr_cnt [NL];
  int          wr_total = 0, load_cnt = 0, save_cnt = 0, done_cnt = 0;
  int          multi_cnt = 0, idx_err_cnt = 0, unstable_cnt = 0, stall_total = 0;
  int          init_ack = 0, out_left = 0, in_left = 0;
  bit          out_armed = 1'b0, in_armed = 1'b0;
  logic [63:0] pending = '0, out_first = '0;
  logic [4:0]  out_first_idx = '0;

  // Controls: written only by the main sequence.
  int          init_seq = 0, init_pat = 0;
  bit          invert = 1'b0, stall_en = 1'b0;

  int          n_checks = 0, n_errors = 0;

  function automatic logic [63:0] init_val(input int pat, input int k);
    logic [63:0] one;
    one = 64'd1;
    if (pat == 1) return one << k;
    return 64'(k) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      mem[k]    = '0;
      wr_cnt[k] = 0;
    end
  end

  // Memory model, protocol monitor and downstream responder in one process.
  always @(negedge clk) begin
    int nstb;
    if (init_seq != init_ack) begin
      for (int k = 0; k < NL; k++) mem[k] = init_val(init_pat, k);
      init_ack = init_seq;
    end
    nstb = int'(mem_load) + int'(mem_save) + int'(mem_read) + int'(mem_write);
    if (nstb > 1) multi_cnt++;
    if (mem_idx > 5'd24) idx_err_cnt++;
    if (mem_load) load_cnt++;
    if (mem_save) save_cnt++;
    if (done) done_cnt++;
    if (mem_read && mem_idx <= 5'd24) mem_rdata = mem[mem_idx];
    if (mem_write && mem_idx <= 5'd24) begin
      mem[mem_idx] = mem_wdata;
      wr_cnt[mem_idx]++;
      wr_total++;
    end
    if (lane_out_valid) begin
      if (!out_armed) begin
        out_armed     = 1'b1;
        out_first     = lane_out;
        out_first_idx = lane_out_idx;
        out_left      = stall_en ? int'($urandom_range(1, 3)) : 0;
      end else if (lane_out !== out_first || lane_out_idx !== out_first_idx) begin
        unstable_cnt++;
      end
      if (out_left > 0) begin
        lane_out_ready = 1'b0;
        out_left--;
        stall_total++;
      end else begin
        lane_out_ready = 1'b1;
        pending        = invert ? ~lane_out : lane_out;
        out_armed      = 1'b0;
      end
    end else begin
      lane_out_ready = !stall_en;
    end
    if (lane_in_ready) begin
      if (!in_armed) begin
        in_armed = 1'b1;
        in_left  = stall_en ? int'($urandom_range(1, 3)) : 0;
      end
      if (in_left > 0) begin
        lane_in_valid = 1'b0;
        lane_in       = 64'hBAD0_BAD0_BAD0_BAD0;
        in_left--;
        stall_total++;
      end else begin
        lane_in_valid = 1'b1;
        lane_in       = pending;
        in_armed      = 1'b0;
      end
    end else begin
      // Junk offered outside RECV must never reach memory.
      lane_in_valid = !stall_en;
      lane_in       = 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  task automatic load_mem(input int pat);
    init_pat = pat;
    init_seq++;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, 64'({busy, done, mem_load, mem_save, mem_read, mem_write,
                                  lane_out_valid, lane_in_ready}), 64'd0);
    check({tag, "_mem_idx"}, 64'(mem_idx), 64'd0);
    check({tag, "_lane_out"}, lane_out, 64'd0);
    check({tag, "_lane_out_idx"}, 64'(lane_out_idx), 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  // Called at a negedge while idle; returns at the negedge of the done cycle.
  task automatic run_sweep(input string tag, input bit hold_start, output int cyc);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    $display("sweep %s: done after %0d cycles", tag, cyc);
  endtask

  task automatic check_mem(input string tag, input bit inv, input int upto);
    for (int k = 0; k < NL; k++)
      check($sformatf("%s_mem[%0d]", tag, k), mem[k],
            (inv && k < upto) ? ~init_val(init_pat, k) : init_val(init_pat, k));
  endtask

  initial begin
    int cyc, snap_load, snap_save, snap_done, snap_wr, snap_stall, snap_unst;
    int wr_snap [NL];
    bit found;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: identity pass-through, handshakes tied high
    load_mem(0);
    for (int k = 0; k < NL; k++) wr_snap[k] = wr_cnt[k];
    snap_load = load_cnt; snap_save = save_cnt; snap_done = done_cnt;
    run_sweep("t1", 1'b0, cyc);
    check("t1_done_cycle", 64'(cyc), 64'd128);
    @(negedge clk);
    check("t1_busy_after", 64'({busy, done}), 64'd0);
    check_mem("t1", 1'b0, 0);
    for (int k = 0; k < NL; k++)
      check($sformatf("t1_writes[%0d]", k), 64'(wr_cnt[k] - wr_snap[k]), 64'd1);
    check("t1_loads", 64'(load_cnt - snap_load), 64'd1);
    check("t1_saves", 64'(save_cnt - snap_save), 64'd1);

    // 2: inverting downstream with random stalls on both handshakes
    invert = 1'b1; stall_en = 1'b1;
    load_mem(0);
    snap_stall = stall_total; snap_unst = unstable_cnt;
    run_sweep("t2", 1'b0, cyc);
    check("t2_done_cycle", 64'(cyc), 64'(128 + stall_total - snap_stall));
    check("t2_stalls_seen", 64'(stall_total - snap_stall >= 50), 64'd1);
    check("t2_lane_out_stable", 64'(unstable_cnt - snap_unst), 64'd0);
    @(negedge clk);
    check_mem("t2", 1'b1, NL);
    invert = 1'b0; stall_en = 1'b0;
    @(negedge clk);

    // 3: start held high through the whole sweep including the done cycle
    load_mem(0);
    snap_load = load_cnt; snap_save = save_cnt; snap_done = done_cnt;
    run_sweep("t3", 1'b1, cyc);
    check("t3_done_cycle", 64'(cyc), 64'd128);
    @(negedge clk);
    start = 1'b0;
    check("t3_idle_after_done", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("t3_still_idle", 64'(busy), 64'd0);
    check("t3_loads", 64'(load_cnt - snap_load), 64'd1);
    check("t3_saves", 64'(save_cnt - snap_save), 64'd1);
    check("t3_dones", 64'(done_cnt - snap_done), 64'd1);

    // 4: reset while waiting for the processed lane of idx 7
    invert = 1'b1;
    load_mem(0);
    snap_save = save_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (lane_in_ready && lane_out_idx == 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("t4_reached_recv7", 64'(found), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("t4_abort");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_no_save", 64'(save_cnt - snap_save), 64'd0);
    check("t4_idle", 64'(busy), 64'd0);
    check_mem("t4", 1'b1, 7);
    invert = 1'b0;

    // 5: three back-to-back sweeps under the protocol monitor
    load_mem(0);
    snap_load = load_cnt; snap_save = save_cnt; snap_done = done_cnt; snap_wr = wr_total;
    for (int s = 0; s < 3; s++) begin
      run_sweep($sformatf("t5_%0d", s), 1'b0, cyc);
      check($sformatf("t5_%0d_done_cycle", s), 64'(cyc), 64'd128);
      @(negedge clk);
    end
    check("t5_writes", 64'(wr_total - snap_wr), 64'd75);
    check("t5_loads", 64'(load_cnt - snap_load), 64'd3);
    check("t5_saves", 64'(save_cnt - snap_save), 64'd3);
    check("t5_dones", 64'(done_cnt - snap_done), 64'd3);
    check("t5_multi_strobe", 64'(multi_cnt), 64'd0);
    check("t5_idx_range", 64'(idx_err_cnt), 64'd0);
    check_mem("t5", 1'b0, 0);

`ifdef LANE_CHECKSUM_EN
    // 6: checksum of one-hot lanes
    load_mem(1);
    run_sweep("t6", 1'b0, cyc);
    check("t6_checksum", checksum, 64'h0000_0000_01FF_FFFF);
    @(negedge clk);
    check("t6_checksum_hold", checksum, 64'h0000_0000_01FF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
